// File: rtl/instruction_memory_loader.sv
// Instruction memory loader: writer side of the instruction memory.
// Accepts a framed byte stream (16-bit little-endian word count, little-endian
// 32-bit instruction words, XOR checksum of the data bytes) over valid/ready,
// issues one word write per instruction starting at BASE_ADDR, and keeps the
// core stalled until a load completes with a matching checksum.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             single-cycle request to begin a load (IDLE/DONE/ERROR only)
//   rx_data/valid     input byte stream; rx_ready is the loader's accept
//   IM_wr_*           instruction memory write port (one-cycle strobe per word)
//   core_hold         stall the core while loading or after an error
//   load_done/error   outcome of the last load
//   words_written     words written in the current or last load
module instruction_memory_loader #(
  parameter int unsigned        ADDR_W    = 32,
  parameter logic [ADDR_W-1:0]  BASE_ADDR = ADDR_W'(1000),
  parameter int unsigned        MAX_WORDS = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              IM_wr_en,
  output logic [ADDR_W-1:0] IM_wr_addr,
  output logic [31:0]       IM_wr_data,
  output logic              core_hold,
  output logic              load_done,
  output logic              load_error,
  output logic [15:0]       words_written
);

  typedef enum logic [2:0] {
    StIdle, StLenLo, StLenHi, StData, StWrite, StCsum, StDone, StError
  } state_e;

  state_e            state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [15:0]       word_idx_q, word_idx_d;
  logic [7:0]        csum_q, csum_d;
  logic [31:0]       word_q, word_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [31:0]       wr_data_q, wr_data_d;
  logic [15:0]       words_written_q, words_written_d;

  logic        xfer;
  logic [15:0] len_new;

  assign xfer    = rx_valid && rx_ready;
  assign len_new = {rx_data, len_q[7:0]};

  always_comb begin
    state_d         = state_q;
    len_d           = len_q;
    byte_idx_d      = byte_idx_q;
    word_idx_d      = word_idx_q;
    csum_d          = csum_q;
    word_d          = word_q;
    wr_addr_d       = wr_addr_q;
    wr_data_d       = wr_data_q;
    words_written_d = words_written_q;

    unique case (state_q)
      StIdle, StDone, StError: begin
        if (start) begin
          state_d         = StLenLo;
          words_written_d = '0;
          byte_idx_d      = '0;
          word_idx_d      = '0;
          csum_d          = '0;
        end
      end
      StLenLo: begin
        if (xfer) begin
          len_d[7:0] = rx_data;
          state_d    = StLenHi;
        end
      end
      StLenHi: begin
        if (xfer) begin
          len_d[15:8] = rx_data;
          if (len_new == 16'd0 || 32'(len_new) > MAX_WORDS) begin
            state_d = StError;
          end else begin
            state_d = StData;
          end
        end
      end
      StData: begin
        if (xfer) begin
          word_d[8*byte_idx_q +: 8] = rx_data;
          csum_d                    = csum_q ^ rx_data;
          byte_idx_d                = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            // Latch address/data now so the write port is driven from flops
            // and holds its value after the strobe drops.
            wr_addr_d = BASE_ADDR + ADDR_W'({word_idx_q, 2'b00});
            wr_data_d = {rx_data, word_q[23:0]};
            state_d   = StWrite;
          end
        end
      end
      StWrite: begin
        word_idx_d      = word_idx_q + 16'd1;
        words_written_d = words_written_q + 16'd1;
        state_d         = (word_idx_q + 16'd1 == len_q) ? StCsum : StData;
      end
      StCsum: begin
        if (xfer) begin
          state_d = (rx_data == csum_q) ? StDone : StError;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= StIdle;
      len_q           <= '0;
      byte_idx_q      <= '0;
      word_idx_q      <= '0;
      csum_q          <= '0;
      word_q          <= '0;
      wr_addr_q       <= '0;
      wr_data_q       <= '0;
      words_written_q <= '0;
    end else begin
      state_q         <= state_d;
      len_q           <= len_d;
      byte_idx_q      <= byte_idx_d;
      word_idx_q      <= word_idx_d;
      csum_q          <= csum_d;
      word_q          <= word_d;
      wr_addr_q       <= wr_addr_d;
      wr_data_q       <= wr_data_d;
      words_written_q <= words_written_d;
    end
  end

  assign rx_ready      = (state_q == StLenLo) || (state_q == StLenHi) ||
                         (state_q == StData)  || (state_q == StCsum);
  assign IM_wr_en      = (state_q == StWrite);
  assign IM_wr_addr    = wr_addr_q;
  assign IM_wr_data    = wr_data_q;
  assign core_hold     = !((state_q == StIdle) || (state_q == StDone));
  assign load_done     = (state_q == StDone);
  assign load_error    = (state_q == StError);
  assign words_written = words_written_q;

endmodule

// File: tb/tb_instruction_memory_loader.sv
// Scoreboard bench for instruction_memory_loader: the stimulus pushes expected
// writes into a queue, a negedge monitor pops and compares on every strobe.
module tb_instruction_memory_loader;

  typedef logic [7:0] byte_q_t[$];
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        IM_wr_en;
  logic [31:0] IM_wr_addr;
  logic [31:0] IM_wr_data;
  logic        core_hold;
  logic        load_done;
  logic        load_error;
  logic [15:0] words_written;

  int  n_cmp = 0;
  int  n_bad = 0;
  wr_t exp_q[$];

  instruction_memory_loader #(
    .ADDR_W   (32),
    .BASE_ADDR(32'd1000),
    .MAX_WORDS(256)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .IM_wr_en     (IM_wr_en),
    .IM_wr_addr   (IM_wr_addr),
    .IM_wr_data   (IM_wr_data),
    .core_hold    (core_hold),
    .load_done    (load_done),
    .load_error   (load_error),
    .words_written(words_written)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst_n && IM_wr_en) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: got %0h/%0h expected none", IM_wr_addr, IM_wr_data);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", {32'd0, IM_wr_addr}, {32'd0, e.addr});
        check("wr_data", {32'd0, IM_wr_data}, {32'd0, e.data});
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Sends bytes; gap_max > 0 inserts random idle cycles with rx_valid low.
  // stalls counts sampled cycles where rx_valid was high but rx_ready low.
  task automatic send_stream(input byte_q_t bytes, input int gap_max, output int stalls);
    stalls = 0;
    foreach (bytes[i]) begin
      bit ok;
      if (gap_max > 0) begin
        int g;
        g = $urandom_range(gap_max, 0);
        rx_valid = 1'b0;
        repeat (g) @(posedge clk);
        #1;
      end
      rx_data  = bytes[i];
      rx_valid = 1'b1;
      ok = 1'b0;
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        if (rx_ready) begin
          ok = 1'b1;
          @(posedge clk);
          #1;
          break;
        end
        stalls++;
      end
      if (!ok) begin
        n_cmp++;
        n_bad++;
        $display("FAIL rx_ready_timeout: got 0 expected 1 (byte %0d)", i);
      end
    end
    rx_valid = 1'b0;
  endtask

  task automatic push_case1();
    exp_q.push_back('{addr: 32'd1000, data: 32'h00A00513});
    exp_q.push_back('{addr: 32'd1004, data: 32'h00100593});
  endtask

  task automatic check_status(input string name, input logic d, input logic e, input logic h,
                              input logic [15:0] w);
    check({name, "_status"}, {45'd0, load_done, load_error, core_hold, words_written},
          {45'd0, d, e, h, w});
  endtask

  byte_q_t case1     = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00,
                         8'h30};
  byte_q_t case1_bad = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00,
                         8'h31};

  initial begin
    int st;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs",
          {rx_ready, IM_wr_en, core_hold, load_done, load_error, words_written, IM_wr_data},
          64'd0);
    check("reset_addr", {32'd0, IM_wr_addr}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: nominal two-word load
    push_case1();
    pulse_start();
    check("lenlo_hold", {62'd0, core_hold, rx_ready}, 64'd3);
    send_stream(case1, 0, st);
    check_status("case1", 1'b1, 1'b0, 1'b0, 16'd2);
    check("addr_hold", {32'd0, IM_wr_addr}, 64'd1004);
    check("data_hold", {32'd0, IM_wr_data}, {32'd0, 32'h00100593});
    // 4: continuous valid stalls exactly once per word
    check("b2b_stalls", 64'(st), 64'd2);

    // 2: bad checksum, writes still occur
    push_case1();
    pulse_start();
    send_stream(case1_bad, 0, st);
    check_status("case2", 1'b0, 1'b1, 1'b1, 16'd2);

    // 3: zero length and oversize length
    pulse_start();
    send_stream('{8'h00, 8'h00}, 0, st);
    check_status("len0", 1'b0, 1'b1, 1'b1, 16'd0);
    pulse_start();
    send_stream('{8'h01, 8'h01}, 0, st);
    check_status("len257", 1'b0, 1'b1, 1'b1, 16'd0);

    // 4b: random valid gaps
    push_case1();
    pulse_start();
    send_stream(case1, 3, st);
    check_status("gaps", 1'b1, 1'b0, 1'b0, 16'd2);

    // 5: asynchronous reset mid-load
    pulse_start();
    send_stream('{8'h02, 8'h00, 8'h13, 8'h05}, 0, st);
    rst_n = 1'b0;
    #2;
    check("async_reset",
          {rx_ready, IM_wr_en, core_hold, load_done, load_error, words_written, IM_wr_data},
          64'd0);
    check("async_reset_addr", {32'd0, IM_wr_addr}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    push_case1();
    pulse_start();
    send_stream(case1, 0, st);
    check_status("post_reset", 1'b1, 1'b0, 1'b0, 16'd2);

    // 6: start during DATA ignored; start in DONE clears status
    push_case1();
    pulse_start();
    send_stream('{8'h02, 8'h00, 8'h13, 8'h05}, 0, st);
    pulse_start();
    send_stream('{8'hA0, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00, 8'h30}, 0, st);
    check_status("start_in_data", 1'b1, 1'b0, 1'b0, 16'd2);
    pulse_start();
    check_status("start_in_done", 1'b0, 1'b0, 1'b1, 16'd0);
    exp_q.push_back('{addr: 32'd1000, data: 32'h12345678});
    send_stream('{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h08}, 0, st);
    check_status("one_word", 1'b1, 1'b0, 1'b0, 16'd1);

    repeat (3) @(posedge clk);
    check("writes_pending", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
